// File: rtl/proj_mux_pkg.sv
// Shared types and helpers for the sequential project multiplexer.
// Holds the controller state encoding, the one-hot helper and the stubbed-slot mask.
package proj_mux_pkg;

    localparam int unsigned MAX_PROJ = 64;

    // Slot 13 is stubbed in the default build.
    localparam logic [15:0] DEFAULT_EMPTY_MASK = 16'h2000;

    typedef enum logic {
        ST_SWITCH = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic logic [MAX_PROJ-1:0] onehot(input logic [5:0] idx);
        logic [MAX_PROJ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/proj_mux_next_sel.sv
// Rotating search for the next populated project slot after cur_sel.
// Returns cur_sel itself when no other slot is populated.
module proj_mux_next_sel #(
    parameter int unsigned N_PROJ = 16,
    localparam int unsigned SEL_W = $clog2(N_PROJ)
) (
    input  logic [SEL_W-1:0]  cur_sel,
    input  logic [N_PROJ-1:0] empty_mask,
    output logic [SEL_W-1:0]  nxt
);

    always_comb begin
        logic found;
        logic [SEL_W-1:0] cand;
        int unsigned j;
        nxt   = cur_sel;
        found = 1'b0;
        cand  = '0;
        j     = 0;
        // k == N_PROJ lands back on cur_sel, so a lone populated slot selects itself.
        for (int unsigned k = 1; k <= N_PROJ; k++) begin
            j    = (32'(cur_sel) + k) % N_PROJ;
            cand = SEL_W'(j);
            if (!found && !empty_mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/proj_mux_seq.sv
// Sequential project multiplexer: registered output, reset window on every switch,
// rejection of stubbed selects, and an optional dwell-timed auto-scan.
module proj_mux_seq
    import proj_mux_pkg::*;
#(
    parameter int unsigned N_PROJ = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned DWELL = 1024,
    parameter int unsigned DEFAULT_SEL = 0,
    parameter logic [N_PROJ-1:0] EMPTY_MASK = N_PROJ'(DEFAULT_EMPTY_MASK),
    localparam int unsigned SEL_W = $clog2(N_PROJ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_PROJ*WIDTH-1:0] proj_out,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    sel_load,
    input  logic                    scan_en,
    output logic [WIDTH-1:0]        uo_out,
    output logic [N_PROJ-1:0]       proj_rst_n,
    output logic [N_PROJ-1:0]       proj_ena,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    busy,
    output logic                    sel_err
);

    localparam int unsigned CNT_MAX = (DWELL > RST_CYCLES) ? DWELL : RST_CYCLES;
    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   uo_q, uo_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   nxt;
    logic               load_valid;
    logic [MAX_PROJ-1:0] sel_onehot;
    logic [WIDTH-1:0]   slots [N_PROJ];

    for (genvar i = 0; i < N_PROJ; i++) begin : g_slots
        assign slots[i] = proj_out[i*WIDTH +: WIDTH];
    end

    proj_mux_next_sel #(
        .N_PROJ (N_PROJ)
    ) u_next_sel (
        .cur_sel    (sel_q),
        .empty_mask (EMPTY_MASK),
        .nxt        (nxt)
    );

    assign load_valid = (32'(sel_in) < N_PROJ) && !EMPTY_MASK[sel_in];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_SWITCH: begin
                err_d = sel_load;
                if (cnt_q == RST_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (scan_en) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (nxt != sel_q) begin
                            sel_d   = nxt;
                            state_d = ST_SWITCH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // A valid load overrides any scan advance decided above.
                if (sel_load) begin
                    if (!load_valid) begin
                        err_d = 1'b1;
                    end else if (sel_in != sel_q) begin
                        sel_d   = sel_in;
                        state_d = ST_SWITCH;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
        uo_d = (state_q == ST_ACTIVE && state_d == ST_ACTIVE) ? slots[sel_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SWITCH;
            cnt_q   <= '0;
            sel_q   <= SEL_W'(DEFAULT_SEL);
            uo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            uo_q    <= uo_d;
            err_q   <= err_d;
        end
    end

    assign sel_onehot = onehot(6'(sel_q));
    assign uo_out     = uo_q;
    assign cur_sel    = sel_q;
    assign sel_err    = err_q;
    assign busy       = (state_q == ST_SWITCH);
    assign proj_ena   = (state_q == ST_ACTIVE) ? sel_onehot[N_PROJ-1:0] : '0;
    assign proj_rst_n = (state_q == ST_ACTIVE) ? sel_onehot[N_PROJ-1:0] : '0;

endmodule
